// File: rtl/avr_cpu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_exec_pipe
// Brief    : AVR execute stage with register file, ALU/SREG, wait-stated I/O
//            port and jump resolution. Define AVR_EXEC_BRANCH_EN to decode
//            BRBS/BRBC.
// Revision : 1.0
// ============================================================================
module avr_cpu_exec_pipe #(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 32,
    parameter int IO_ADDR_W  = 6,
    parameter int IO_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [15:0]          opcode,
    output logic                 op_ready,
    output logic                 jmp_valid,
    output logic [11:0]          jmp_offset,
    output logic [IO_ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0]    io_wdata,
    input  logic [DATA_W-1:0]    io_rdata,
    output logic                 io_read,
    output logic                 io_write,
    input  logic                 io_ready,
    output logic                 io_err,
    output logic [7:0]           sreg
);

    localparam int c_RA_W  = $clog2(REG_COUNT);
    localparam int c_CNT_W = $clog2(IO_TIMEOUT + 1);
    localparam int c_MSB   = DATA_W - 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_IO   = 1'b1;

    logic [0:0]             r_state;
    logic [DATA_W-1:0]      r_regs [REG_COUNT];
    logic [7:0]             r_sreg;
    logic                   r_jmp_valid;
    logic [11:0]            r_jmp_offset;
    logic [IO_ADDR_W-1:0]   r_io_addr;
    logic [DATA_W-1:0]      r_io_wdata;
    logic                   r_io_read;
    logic                   r_io_write;
    logic                   r_io_err;
    logic [c_CNT_W-1:0]     r_io_cnt;
    logic [c_RA_W-1:0]      r_io_dst;

    logic                   w_accept;
    logic [5:0]             w_op6;
    logic [3:0]             w_op4;
    logic [4:0]             w_op5;
    logic [4:0]             w_d5;
    logic [4:0]             w_r5;
    logic [4:0]             w_dh5;
    logic [7:0]             w_k8;
    logic [5:0]             w_a6;
    logic [c_RA_W-1:0]      w_d_idx;
    logic [c_RA_W-1:0]      w_r_idx;
    logic [c_RA_W-1:0]      w_dh_idx;
    logic [c_RA_W-1:0]      w_dst;
    logic                   w_is_imm;
    logic                   w_is_in;
    logic                   w_is_out;
    logic                   w_is_rjmp;
    logic                   w_br_taken;
    logic [11:0]            w_br_off;
    logic                   w_jump;
    logic [11:0]            w_jump_off;
    logic [DATA_W-1:0]      w_a;
    logic [DATA_W-1:0]      w_b;
    logic [DATA_W-1:0]      w_imm;
    logic [DATA_W:0]        w_sum;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_res;
    logic                   w_wr;
    logic                   w_upd;
    logic                   w_c;
    logic                   w_v;
    logic                   w_n;
    logic                   w_z;
    logic [7:0]             w_new_sreg;

    assign w_accept = op_valid & op_ready;

    // Field extraction follows the standard AVR encodings
    assign w_op6    = opcode[15:10];
    assign w_op5    = opcode[15:11];
    assign w_op4    = opcode[15:12];
    assign w_d5     = opcode[8:4];
    assign w_r5     = {opcode[9], opcode[3:0]};
    assign w_dh5    = {1'b1, opcode[7:4]};
    assign w_k8     = {opcode[11:8], opcode[3:0]};
    assign w_a6     = {opcode[10:9], opcode[3:0]};
    assign w_d_idx  = w_d5[c_RA_W-1:0];
    assign w_r_idx  = w_r5[c_RA_W-1:0];
    assign w_dh_idx = w_dh5[c_RA_W-1:0];
    assign w_imm    = DATA_W'(w_k8);

    assign w_is_imm  = (w_op4 == 4'b1110) || (w_op4 == 4'b0101) ||
                       (w_op4 == 4'b0110) || (w_op4 == 4'b0111);
    assign w_is_in   = (w_op5 == 5'b10110);
    assign w_is_out  = (w_op5 == 5'b10111);
    assign w_is_rjmp = (w_op4 == 4'b1100);

    assign w_dst = w_is_imm ? w_dh_idx : w_d_idx;
    assign w_a   = r_regs[w_dst];
    assign w_b   = w_is_imm ? w_imm : r_regs[w_r_idx];

    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

`ifdef AVR_EXEC_BRANCH_EN
    // sreg already holds the flags of the preceding instruction
    assign w_br_taken = ((w_op6 == 6'b111100) &  r_sreg[opcode[2:0]]) |
                        ((w_op6 == 6'b111101) & ~r_sreg[opcode[2:0]]);
    assign w_br_off   = {{5{opcode[9]}}, opcode[9:3]};
`else
    assign w_br_taken = 1'b0;
    assign w_br_off   = 12'h000;
`endif

    assign w_jump     = w_is_rjmp | w_br_taken;
    assign w_jump_off = w_is_rjmp ? opcode[11:0] : w_br_off;

    always_comb begin
        w_res = '0;
        w_wr  = 1'b0;
        w_upd = 1'b0;
        w_c   = r_sreg[0];
        w_v   = 1'b0;
        if (w_op6 == 6'b000011) begin
            w_res = w_sum[DATA_W-1:0];
            w_wr  = 1'b1;
            w_upd = 1'b1;
            w_c   = w_sum[DATA_W];
            w_v   = (w_a[c_MSB] == w_b[c_MSB]) && (w_res[c_MSB] != w_a[c_MSB]);
        end else if ((w_op6 == 6'b000110) || (w_op4 == 4'b0101)) begin
            w_res = w_diff[DATA_W-1:0];
            w_wr  = 1'b1;
            w_upd = 1'b1;
            w_c   = w_diff[DATA_W];
            w_v   = (w_a[c_MSB] != w_b[c_MSB]) && (w_res[c_MSB] != w_a[c_MSB]);
        end else if ((w_op6 == 6'b001000) || (w_op4 == 4'b0111)) begin
            w_res = w_a & w_b;
            w_wr  = 1'b1;
            w_upd = 1'b1;
        end else if ((w_op6 == 6'b001010) || (w_op4 == 4'b0110)) begin
            w_res = w_a | w_b;
            w_wr  = 1'b1;
            w_upd = 1'b1;
        end else if (w_op6 == 6'b001001) begin
            w_res = w_a ^ w_b;
            w_wr  = 1'b1;
            w_upd = 1'b1;
        end else if ((w_op6 == 6'b001011) || (w_op4 == 4'b1110)) begin
            w_res = w_b;
            w_wr  = 1'b1;
        end
    end

    assign w_n        = w_res[c_MSB];
    assign w_z        = (w_res == '0);
    assign w_new_sreg = {3'b000, w_n ^ w_v, w_v, w_n, w_z, w_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_sreg       <= 8'h00;
            r_jmp_valid  <= 1'b0;
            r_jmp_offset <= 12'h000;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
            r_io_read    <= 1'b0;
            r_io_write   <= 1'b0;
            r_io_err     <= 1'b0;
            r_io_cnt     <= '0;
            r_io_dst     <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_jmp_valid <= 1'b0;
            r_io_err    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_wr) begin
                            r_regs[w_dst] <= w_res;
                        end
                        if (w_upd) begin
                            r_sreg <= w_new_sreg;
                        end
                        if (w_jump) begin
                            r_jmp_valid  <= 1'b1;
                            r_jmp_offset <= w_jump_off;
                        end
                        if (w_is_in || w_is_out) begin
                            r_state    <= c_ST_IO;
                            r_io_addr  <= IO_ADDR_W'(w_a6);
                            r_io_cnt   <= '0;
                            r_io_read  <= w_is_in;
                            r_io_write <= w_is_out;
                            r_io_dst   <= w_d_idx;
                            if (w_is_out) begin
                                r_io_wdata <= r_regs[w_d_idx];
                            end
                        end
                    end
                end
                c_ST_IO: begin
                    if (io_ready) begin
                        r_state    <= c_ST_IDLE;
                        r_io_read  <= 1'b0;
                        r_io_write <= 1'b0;
                        if (r_io_read) begin
                            r_regs[r_io_dst] <= io_rdata;
                        end
                    end else if (r_io_cnt == c_CNT_W'(IO_TIMEOUT - 1)) begin
                        // Last permitted strobe cycle expired: abort the access
                        r_state    <= c_ST_IDLE;
                        r_io_read  <= 1'b0;
                        r_io_write <= 1'b0;
                        r_io_err   <= 1'b1;
                    end else begin
                        r_io_cnt <= r_io_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign op_ready   = (r_state == c_ST_IDLE);
    assign jmp_valid  = r_jmp_valid;
    assign jmp_offset = r_jmp_offset;
    assign io_addr    = r_io_addr;
    assign io_wdata   = r_io_wdata;
    assign io_read    = r_io_read;
    assign io_write   = r_io_write;
    assign io_err     = r_io_err;
    assign sreg       = r_sreg;

endmodule
`default_nettype wire

// File: tb/tb_avr_cpu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_avr_cpu_exec_pipe
// Brief    : Directed plus randomized bench for avr_cpu_exec_pipe against an
//            arithmetic reference model; honours AVR_EXEC_BRANCH_EN.
// Revision : 1.0
// ============================================================================
module tb_avr_cpu_exec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [15:0] opcode = 16'h0000;
    logic        op_ready;
    logic        jmp_valid;
    logic [11:0] jmp_offset;
    logic [5:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = 8'h00;
    logic        io_read;
    logic        io_write;
    logic        io_ready = 1'b0;
    logic        io_err;
    logic [7:0]  sreg;

    int n_assert = 0;
    int n_fail   = 0;

    int m_regs [32];
    int m_sreg;

    avr_cpu_exec_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .opcode     (opcode),
        .op_ready   (op_ready),
        .jmp_valid  (jmp_valid),
        .jmp_offset (jmp_offset),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_ready   (io_ready),
        .io_err     (io_err),
        .sreg       (sreg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kinds: 0 ADD 1 SUB 2 AND 3 EOR 4 OR 5 MOV 6 LDI 7 SUBI 8 ORI 9 ANDI
    function automatic logic [15:0] enc(input int kind, input int d, input int r, input int k);
        logic [4:0]  dd;
        logic [4:0]  rr;
        logic [7:0]  kk;
        logic [3:0]  dh;
        logic [5:0]  op6;
        logic [3:0]  op4;
        dd = d[4:0];
        rr = r[4:0];
        kk = k[7:0];
        dh = dd[3:0];
        op6 = 6'b000000;
        op4 = 4'b0000;
        case (kind)
            0: op6 = 6'b000011;
            1: op6 = 6'b000110;
            2: op6 = 6'b001000;
            3: op6 = 6'b001001;
            4: op6 = 6'b001010;
            5: op6 = 6'b001011;
            6: op4 = 4'b1110;
            7: op4 = 4'b0101;
            8: op4 = 4'b0110;
            default: op4 = 4'b0111;
        endcase
        if (kind <= 5) return {op6, rr[4], dd, rr[3:0]};
        return {op4, kk[7:4], dh, kk[3:0]};
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void model(input int kind, input int d, input int r, input int k);
        int a, b, res, c, v, n, z, sv;
        a = m_regs[d];
        b = (kind >= 6) ? k : m_regs[r];
        c = m_sreg & 1;
        v = 0;
        res = 0;
        case (kind)
            0: begin
                res = a + b;
                c = (res > 255) ? 1 : 0;
                sv = sgn(a) + sgn(b);
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            1, 7: begin
                res = a - b;
                c = (a < b) ? 1 : 0;
                sv = sgn(a) - sgn(b);
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            2, 9: res = a & b;
            3:    res = a ^ b;
            4, 8: res = a | b;
            default: res = b;
        endcase
        res = res & 255;
        m_regs[d] = res;
        if (kind != 5 && kind != 6) begin
            n = res / 128;
            z = (res == 0) ? 1 : 0;
            m_sreg = ((n ^ v) << 4) | (v << 3) | (n << 2) | (z << 1) | c;
        end
    endfunction

    task automatic send(input logic [15:0] op);
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = op;
        @(negedge clk);
        op_valid = 1'b0;
        opcode   = $urandom;
    endtask

    task automatic alu(input int kind, input int d, input int r, input int k);
        model(kind, d, r, k);
        send(enc(kind, d, r, k));
        chk($sformatf("sreg_k%0d_d%0d", kind, d), {24'h0, sreg}, m_sreg);
    endtask

    // Reads a register back through OUT with zero wait states
    task automatic readreg(input int idx);
        send({5'b10111, 2'b00, idx[4:0], 4'h1});
        chk($sformatf("out_wr_r%0d", idx), {31'h0, io_write}, 1);
        chk($sformatf("out_data_r%0d", idx), {24'h0, io_wdata}, m_regs[idx]);
        io_ready = 1'b1;
        @(negedge clk);
        io_ready = 1'b0;
    endtask

    initial begin
        int cnt, kind, d, r, k;
        logic [7:0] rd;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_sreg = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_op_ready", {31'h0, op_ready}, 1);
        chk("rst_jmp",      {31'h0, jmp_valid}, 0);
        chk("rst_io_rd",    {31'h0, io_read}, 0);
        chk("rst_io_wr",    {31'h0, io_write}, 0);
        chk("rst_io_err",   {31'h0, io_err}, 0);
        chk("rst_io_addr",  {26'h0, io_addr}, 0);
        chk("rst_io_wdata", {24'h0, io_wdata}, 0);
        chk("rst_sreg",     {24'h0, sreg}, 0);
        readreg(5);

        // Overflow into the sign bit
        alu(6, 16, 0, 8'h7F);
        alu(6, 17, 0, 8'h01);
        alu(0, 16, 17, 0);
        chk("add_sreg_0C", {24'h0, sreg}, 8'h0C);
        readreg(16);

        alu(6, 16, 0, 8'h05);
        alu(7, 16, 0, 8'h05);
        chk("subi_zero", {30'h0, sreg[1:0]}, 2'b10);
        alu(7, 16, 0, 8'h01);
        chk("subi_borrow", {29'h0, sreg[2], sreg[1:0]}, 3'b101);
        readreg(16);

        // OUT with three strobe cycles
        send({5'b10111, 2'b11, 5'd16, 4'hF});
        for (int i = 0; i < 3; i++) begin
            chk("out_wait_wr",    {31'h0, io_write}, 1);
            chk("out_wait_addr",  {26'h0, io_addr}, 6'h3F);
            chk("out_wait_data",  {24'h0, io_wdata}, m_regs[16]);
            chk("out_wait_ready", {31'h0, op_ready}, 0);
            if (i == 2) io_ready = 1'b1;
            @(negedge clk);
        end
        io_ready = 1'b0;
        chk("out_done_wr",    {31'h0, io_write}, 0);
        chk("out_done_ready", {31'h0, op_ready}, 1);

        // IN that never completes
        send({5'b10110, 2'b01, 5'd1, 4'h0});
        cnt = 0;
        for (int i = 0; i < 40 && io_read; i++) begin
            chk("in_to_addr", {26'h0, io_addr}, 6'h10);
            cnt++;
            @(negedge clk);
        end
        chk("in_to_cycles", cnt, 15);
        chk("in_to_err",    {31'h0, io_err}, 1);
        chk("in_to_ready",  {31'h0, op_ready}, 1);
        @(negedge clk);
        chk("in_to_err_pulse", {31'h0, io_err}, 0);
        readreg(1);

        // io_ready while idle has no effect
        io_ready = 1'b1;
        @(negedge clk);
        io_ready = 1'b0;
        chk("idle_ready_rd", {31'h0, io_read}, 0);
        chk("idle_ready_or", {31'h0, op_ready}, 1);

        // Successful IN, single strobe cycle
        rd = 8'($urandom);
        send({5'b10110, 2'b00, 5'd2, 4'h5});
        chk("in_rd_strobe", {31'h0, io_read}, 1);
        chk("in_rd_addr",   {26'h0, io_addr}, 6'h05);
        io_rdata = rd;
        io_ready = 1'b1;
        @(negedge clk);
        io_ready = 1'b0;
        m_regs[2] = rd;
        chk("in_rd_done", {31'h0, io_read}, 0);
        readreg(2);

        // RJMP and NOP
        send({4'hC, 12'hFFE});
        chk("rjmp_valid", {31'h0, jmp_valid}, 1);
        chk("rjmp_off",   {20'h0, jmp_offset}, 12'hFFE);
        chk("rjmp_ready", {31'h0, op_ready}, 1);
        @(negedge clk);
        chk("rjmp_pulse", {31'h0, jmp_valid}, 0);
        send(16'h0000);
        chk("nop_jmp",  {31'h0, jmp_valid}, 0);
        chk("nop_sreg", {24'h0, sreg}, m_sreg);

        // Branches on Z after a zero result
        alu(6, 20, 0, 3);
        alu(7, 20, 0, 3);
        send({6'b111100, 7'h7D, 3'd1});
`ifdef AVR_EXEC_BRANCH_EN
        chk("brbs_taken", {31'h0, jmp_valid}, 1);
        chk("brbs_off",   {20'h0, jmp_offset}, 12'hFFD);
`else
        chk("brbs_nop", {31'h0, jmp_valid}, 0);
`endif
        send({6'b111101, 7'h05, 3'd1});
        chk("brbc_not_taken", {31'h0, jmp_valid}, 0);

        // Randomized ALU traffic
        for (int i = 0; i < 32; i++) alu(6, 16 + (i % 16), 0, $urandom_range(0, 255));
        for (int i = 0; i < 16; i++) alu(5, i, 16 + i, 0);
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            d = (kind >= 6) ? $urandom_range(16, 31) : $urandom_range(0, 31);
            r = $urandom_range(0, 31);
            k = $urandom_range(0, 255);
            alu(kind, d, r, k);
            if ((i % 4) == 0) readreg($urandom_range(0, 31));
        end
        for (int i = 0; i < 32; i++) readreg(i);

        // Asynchronous reset in the middle of an IN
        send({5'b10110, 2'b00, 5'd3, 4'h2});
        chk("arst_pre_rd", {31'h0, io_read}, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_drop", {31'h0, io_read}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_sreg = 0;
        chk("arst_ready", {31'h0, op_ready}, 1);
        chk("arst_sreg",  {24'h0, sreg}, 0);
        readreg(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
